// File: rtl/ch_csr_arbiter_if.sv
// ch_csr_arbiter_if
// Bundles the two requester command ports and the downstream CSR port of
// ch_csr_arbiter so they can be passed as a single port.
//   iREQx_*        : command pulses, address and write data from requester x
//   oREQx_*        : busy / done / drop / read result back to requester x
//   oMM_* / iMM_*  : single downstream CSR port towards the address decoder
//   oTIMEOUT_CNT   : saturating count of abandoned reads
// modport slave is the arbiter side; modport master is the requester/decoder side.
interface ch_csr_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
);
    logic              iREQ0_WR_EN;
    logic              iREQ0_RD_EN;
    logic [ADDR_W-1:0] iREQ0_ADDR;
    logic [DATA_W-1:0] iREQ0_WR_DATA;
    logic              oREQ0_BUSY;
    logic              oREQ0_DONE;
    logic [DATA_W-1:0] oREQ0_RD_DATA;
    logic              oREQ0_DROP;

    logic              iREQ1_WR_EN;
    logic              iREQ1_RD_EN;
    logic [ADDR_W-1:0] iREQ1_ADDR;
    logic [DATA_W-1:0] iREQ1_WR_DATA;
    logic              oREQ1_BUSY;
    logic              oREQ1_DONE;
    logic [DATA_W-1:0] oREQ1_RD_DATA;
    logic              oREQ1_DROP;

    logic              oMM_WR_EN;
    logic              oMM_RD_EN;
    logic [ADDR_W-1:0] oMM_ADDR;
    logic [DATA_W-1:0] oMM_WR_DATA;
    logic [DATA_W-1:0] iMM_RD_DATA;
    logic              iMM_RD_DATA_V;
    logic [15:0]       oTIMEOUT_CNT;

    modport slave (
        input  iREQ0_WR_EN, iREQ0_RD_EN, iREQ0_ADDR, iREQ0_WR_DATA,
        output oREQ0_BUSY, oREQ0_DONE, oREQ0_RD_DATA, oREQ0_DROP,
        input  iREQ1_WR_EN, iREQ1_RD_EN, iREQ1_ADDR, iREQ1_WR_DATA,
        output oREQ1_BUSY, oREQ1_DONE, oREQ1_RD_DATA, oREQ1_DROP,
        output oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA,
        input  iMM_RD_DATA, iMM_RD_DATA_V,
        output oTIMEOUT_CNT
    );

    modport master (
        output iREQ0_WR_EN, iREQ0_RD_EN, iREQ0_ADDR, iREQ0_WR_DATA,
        input  oREQ0_BUSY, oREQ0_DONE, oREQ0_RD_DATA, oREQ0_DROP,
        output iREQ1_WR_EN, iREQ1_RD_EN, iREQ1_ADDR, iREQ1_WR_DATA,
        input  oREQ1_BUSY, oREQ1_DONE, oREQ1_RD_DATA, oREQ1_DROP,
        input  oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA,
        output iMM_RD_DATA, iMM_RD_DATA_V,
        input  oTIMEOUT_CNT
    );
endinterface

// File: rtl/ch_csr_arbiter.sv
// ch_csr_arbiter
// Shares one channel CSR port between the host MM path (requester 0) and the
// local channel sequencer (requester 1). Each requester has a one-deep command
// slot; slots are served round-robin with a single transaction outstanding.
// Reads that get no response within TIMEOUT cycles complete with the marker
// {32'hDEAD_BEEF, zero-extended address}.
// Ports:
//   clk : single clock
//   rst : asynchronous active-high reset
//   bus : ch_csr_arbiter_if.slave (requester commands/status, downstream port,
//         timeout counter)
module ch_csr_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    ch_csr_arbiter_if.slave     bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // The timer counts from 0 in the first WAIT_RD cycle, so the read is
    // abandoned in the cycle where the increment would make it reach TIMEOUT.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        req_wr;
    logic [1:0]        req_rd;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];

    logic [1:0]        slot_v;
    logic [1:0]        slot_wr;
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];

    logic [1:0]        done_q;
    logic [1:0]        drop_q;
    logic [DATA_W-1:0] rd_data_q [2];

    logic [1:0]        state;
    logic              last_grant;
    logic              gnt;
    logic              grant_sel;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       timer;
    logic [15:0]       timeout_cnt;
    logic              mm_wr_q;
    logic              mm_rd_q;
    logic [ADDR_W-1:0] mm_addr_q;
    logic [DATA_W-1:0] mm_wdata_q;
    logic [DATA_W-1:0] marker;

    assign req_wr      = {bus.iREQ1_WR_EN, bus.iREQ0_WR_EN};
    assign req_rd      = {bus.iREQ1_RD_EN, bus.iREQ0_RD_EN};
    assign req_addr[0] = bus.iREQ0_ADDR;
    assign req_addr[1] = bus.iREQ1_ADDR;
    assign req_data[0] = bus.iREQ0_WR_DATA;
    assign req_data[1] = bus.iREQ1_WR_DATA;

    assign bus.oREQ0_BUSY    = slot_v[0];
    assign bus.oREQ1_BUSY    = slot_v[1];
    assign bus.oREQ0_DONE    = done_q[0];
    assign bus.oREQ1_DONE    = done_q[1];
    assign bus.oREQ0_DROP    = drop_q[0];
    assign bus.oREQ1_DROP    = drop_q[1];
    assign bus.oREQ0_RD_DATA = rd_data_q[0];
    assign bus.oREQ1_RD_DATA = rd_data_q[1];
    assign bus.oMM_WR_EN     = mm_wr_q;
    assign bus.oMM_RD_EN     = mm_rd_q;
    assign bus.oMM_ADDR      = mm_addr_q;
    assign bus.oMM_WR_DATA   = mm_wdata_q;
    assign bus.oTIMEOUT_CNT  = timeout_cnt;

    // With both slots pending the requester that was not granted last wins;
    // otherwise the only pending one is chosen.
    always_comb begin
        grant_sel = slot_v[1];
        if (slot_v[0] && slot_v[1]) begin
            grant_sel = ~last_grant;
        end
    end

    // Timeout marker; the high word is placed last so it always survives.
    always_comb begin
        marker                  = '0;
        marker[ADDR_W-1:0]      = cmd_addr;
        marker[DATA_W-1 -: 32]  = 32'hDEAD_BEEF;
    end

    // Per-requester command slot. A pulse in the requester's own DONE cycle
    // reloads the slot instead of letting it clear, so BUSY never drops.
    // Write beats read when both pulses arrive together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v  <= '0;
            slot_wr <= '0;
            drop_q  <= '0;
            for (int r = 0; r < 2; r++) begin
                slot_addr[r] <= '0;
                slot_data[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (req_wr[r] || req_rd[r]) begin
                    if (!slot_v[r] || done_q[r]) begin
                        slot_v[r]    <= 1'b1;
                        slot_wr[r]   <= req_wr[r];
                        slot_addr[r] <= req_addr[r];
                        slot_data[r] <= req_data[r];
                    end else begin
                        drop_q[r] <= 1'b1;
                    end
                end else if (done_q[r]) begin
                    slot_v[r] <= 1'b0;
                end
            end
        end
    end

    // Transaction sequencer. Strobes and DONE are loaded on the transition
    // into ISSUE / DONE so they are registered and last exactly one cycle.
    // Read data valid is only looked at in WAIT_RD, so late responses after
    // a timeout fall on the floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            gnt          <= 1'b0;
            cmd_wr       <= 1'b0;
            cmd_addr     <= '0;
            timer        <= '0;
            timeout_cnt  <= '0;
            mm_wr_q      <= 1'b0;
            mm_rd_q      <= 1'b0;
            mm_addr_q    <= '0;
            mm_wdata_q   <= '0;
            done_q       <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
        end else begin
            mm_wr_q <= 1'b0;
            mm_rd_q <= 1'b0;
            done_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (|slot_v) begin
                        gnt        <= grant_sel;
                        last_grant <= grant_sel;
                        cmd_wr     <= slot_wr[grant_sel];
                        cmd_addr   <= slot_addr[grant_sel];
                        mm_wr_q    <= slot_wr[grant_sel];
                        mm_rd_q    <= ~slot_wr[grant_sel];
                        mm_addr_q  <= slot_addr[grant_sel];
                        mm_wdata_q <= slot_data[grant_sel];
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_wr) begin
                        done_q[gnt] <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        timer <= '0;
                        state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (bus.iMM_RD_DATA_V) begin
                        rd_data_q[gnt] <= bus.iMM_RD_DATA;
                        done_q[gnt]    <= 1'b1;
                        state          <= ST_DONE;
                    end else if (timer == TIMER_LAST) begin
                        rd_data_q[gnt] <= marker;
                        done_q[gnt]    <= 1'b1;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                        state <= ST_DONE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
